alu_seq: RTL



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_shift_step.sv | 31 +++
 rtl/alu_seq.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU operation codes and sequencer state encoding
//
// Purpose: ALU_Cnt operation codes shared between alu_control (producer) and
//          alu_seq (consumer), plus the alu_seq state encoding.
// Ports:   none (package).

package alu_pkg;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SRA  = 3'b010;
    localparam logic [2:0] ALU_SLL  = 3'b011;
    localparam logic [2:0] ALU_SRL  = 3'b100;
    localparam logic [2:0] ALU_AND  = 3'b101;
    localparam logic [2:0] ALU_XOR  = 3'b110;
    localparam logic [2:0] ALU_PASS = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } alu_state_e;

    function automatic logic is_shift_op(input logic [2:0] code);
        return (code == ALU_SRA) || (code == ALU_SLL) || (code == ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_shift_step.sv
// rtl/alu_shift_step.sv - combinational one-position shifter
//
// Purpose: shifts a value by exactly one bit position.
// Ports:
//   value_i   in   WIDTH  value to shift
//   dir_i     in   1      1 = left, 0 = right
//   arith_i   in   1      right shifts replicate the sign bit when set
//   result_o  out  WIDTH  shifted value

module alu_shift_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value_i,
    input  logic             dir_i,
    input  logic             arith_i,
    output logic [WIDTH-1:0] result_o
);

    logic fill_bit;

    assign fill_bit = arith_i & value_i[WIDTH-1];

    always_comb begin
        if (dir_i) begin
            result_o = {value_i[WIDTH-2:0], 1'b0};
        end else begin
            result_o = {fill_bit, value_i[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - sequential integer ALU with iterative shifter
//
// Purpose: executes ALU_Cnt operations accepted over a valid/ready handshake.
//          Logic/add/sub complete in one cycle; shifts take one cycle per bit.
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      operands and ALU_Cnt valid
//   in_ready   out  1      operation can be accepted this cycle
//   ALU_Cnt    in   3      operation code
//   A          in   WIDTH  operand A
//   B          in   WIDTH  operand B (shift amount in B[SHW-1:0])
//   out_valid  out  1      Result/Zero valid
//   out_ready  in   1      consumer accepts the result
//   Result     out  WIDTH  operation result
//   Zero       out  1      Result equals zero
//   busy       out  1      shift in progress

module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALU_Cnt,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             busy
);

    alu_state_e       state_q;
    logic [WIDTH-1:0] result_q;
    logic             zero_q;
    logic             out_valid_q;
    logic             busy_q;
    logic [SHW-1:0]   cnt_q;
    logic             dir_q;
    logic             arith_q;

    logic             accept;
    logic [SHW-1:0]   shamt;
    logic             start_shift;
    logic [WIDTH-1:0] op_result_d;
    logic [WIDTH-1:0] shift_result_d;

    // Combinational from out_ready so a held result and a new op can swap in one cycle.
    assign in_ready    = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept      = in_valid & in_ready;
    assign shamt       = B[SHW-1:0];
    assign start_shift = is_shift_op(ALU_Cnt) && (shamt != '0);

    // Single-cycle result; shifts by zero degenerate to passing A through.
    always_comb begin
        op_result_d = A;
        case (ALU_Cnt)
            ALU_ADD: op_result_d = A + B;
            ALU_SUB: op_result_d = A - B;
            ALU_AND: op_result_d = A & B;
            ALU_XOR: op_result_d = A ^ B;
            default: op_result_d = A;
        endcase
    end

    alu_shift_step #(
        .WIDTH (WIDTH)
    ) u_shift_step (
        .value_i  (result_q),
        .dir_i    (dir_q),
        .arith_i  (arith_q),
        .result_o (shift_result_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cnt_q       <= '0;
            dir_q       <= 1'b0;
            arith_q     <= 1'b0;
        end else if (accept) begin
            if (start_shift) begin
                state_q     <= ST_SHIFT;
                result_q    <= A;
                zero_q      <= (A == '0);
                cnt_q       <= shamt;
                dir_q       <= (ALU_Cnt == ALU_SLL);
                arith_q     <= (ALU_Cnt == ALU_SRA);
                out_valid_q <= 1'b0;
                busy_q      <= 1'b1;
            end else begin
                state_q     <= ST_DONE;
                result_q    <= op_result_d;
                zero_q      <= (op_result_d == '0);
                out_valid_q <= 1'b1;
                busy_q      <= 1'b0;
            end
        end else begin
            case (state_q)
                ST_SHIFT: begin
                    result_q <= shift_result_d;
                    zero_q   <= (shift_result_d == '0);
                    cnt_q    <= cnt_q - SHW'(1);
                    if (cnt_q == SHW'(1)) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                ST_DONE: begin
                    // in_valid with out_ready is handled by the accept branch above.
                    if (out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign Result    = result_q;
    assign Zero      = zero_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
